// File: rtl/serial_add_ctrl_v_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encodings and the one-bit full-add function used by the adder cell.
package serial_add_ctrl_v_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    // Returns {carry_out, sum} for a single bit position.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic s;
        logic co;
        s  = a ^ b ^ c;
        co = (a & b) | (a & c) | (b & c);
        return {co, s};
    endfunction

endpackage

// File: rtl/serial_add_ctrl_v_calc.sv
// One-bit unsigned full-adder cell, reused every cycle by the serial controller.
module unsigned_calc_v
    import serial_add_ctrl_v_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_carry,
    output logic o_s,
    output logic o_carry
);

    assign {o_carry, o_s} = full_add(i_a, i_b, i_carry);

endmodule

// File: rtl/serial_add_ctrl_v.sv
// Bit-serial unsigned adder: one full-adder cell iterated WIDTH times, LSB first,
// between a start valid/ready requester and a done valid/ready consumer.
module serial_add_ctrl_v
    import serial_add_ctrl_v_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start_valid,
    output logic             o_start_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    output logic [WIDTH-1:0] o_s,
    output logic             o_carry,
    output logic             o_done_valid,
    input  logic             i_done_ready,
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-2:0]   sum_sr;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt;
    logic               cell_s;
    logic               cell_c;
    logic [WIDTH-1:0]   sum_next;

    unsigned_calc_v u_cell (
        .i_a     (a_sr[0]),
        .i_b     (b_sr[0]),
        .i_carry (carry_r),
        .o_s     (cell_s),
        .o_carry (cell_c)
    );

    // Sum fills from the MSB end; the bit about to fall off the bottom is never
    // needed, so only WIDTH-1 bits of history are stored.
    assign sum_next = {cell_s, sum_sr};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            a_sr          <= '0;
            b_sr          <= '0;
            sum_sr        <= '0;
            carry_r       <= 1'b0;
            cnt           <= '0;
            o_s           <= '0;
            o_carry       <= 1'b0;
            o_start_ready <= 1'b1;
            o_done_valid  <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start_valid) begin
                        a_sr          <= i_a;
                        b_sr          <= i_b;
                        carry_r       <= i_carry;
                        sum_sr        <= '0;
                        cnt           <= '0;
                        state         <= ST_RUN;
                        o_start_ready <= 1'b0;
                        o_busy        <= 1'b1;
                    end
                end
                ST_RUN: begin
                    sum_sr  <= sum_next[WIDTH-1:1];
                    carry_r <= cell_c;
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    if (cnt == CNT_LAST) begin
                        // Outputs change only here, so a partial sum is never visible.
                        o_s          <= sum_next;
                        o_carry      <= cell_c;
                        o_done_valid <= 1'b1;
                        o_busy       <= 1'b0;
                        state        <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_done_ready) begin
                        o_done_valid  <= 1'b0;
                        o_start_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    o_start_ready <= 1'b1;
                    o_done_valid  <= 1'b0;
                    o_busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl_v.sv
// Scoreboard bench for serial_add_ctrl_v: stimulus queues expected sums,
// a negedge monitor pops them on each done handshake.
module tb_serial_add_ctrl_v;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] ia;
    logic [WIDTH-1:0] ib;
    logic             icarry;
    logic [WIDTH-1:0] os;
    logic             ocarry;
    logic             done_valid;
    logic             done_ready;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [WIDTH:0] sb[$];
    logic [WIDTH:0] mon_exp;

    serial_add_ctrl_v #(.WIDTH(WIDTH)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start_valid (start_valid),
        .o_start_ready (start_ready),
        .i_a           (ia),
        .i_b           (ib),
        .i_carry       (icarry),
        .o_s           (os),
        .o_carry       (ocarry),
        .o_done_valid  (done_valid),
        .i_done_ready  (done_ready),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done_valid && done_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=%0h required=none", {ocarry, os});
            end else begin
                mon_exp = sb.pop_front();
                chk("result", 32'({ocarry, os}), 32'(mon_exp));
            end
        end
    end

    task automatic do_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic c, input bit push, input logic [WIDTH:0] exp,
                            output int t_acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!start_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) chk("start_ready_timeout", 32'(start_ready), 32'd1);
        ia          = a;
        ib          = b;
        icarry      = c;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        t_acc       = cyc;
        start_valid = 1'b0;
        if (push) sb.push_back(exp);
    endtask

    task automatic wait_done(input int t_acc, output int lat);
        int n;
        n = 0;
        while (!done_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done_valid) chk("done_timeout", 32'(done_valid), 32'd1);
        lat = cyc - t_acc;
    endtask

    initial begin
        int t1, t2, lat, n;
        bit seen;
        rst         = 1'b1;
        start_valid = 1'b0;
        ia          = '0;
        ib          = '0;
        icarry      = 1'b0;
        done_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start_ready", 32'(start_ready), 32'd1);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'({ocarry, os}), 32'd0);
        rst = 1'b0;

        // 0x5A + 0x33 = 0x8D, with RUN-time and DONE-time disturbances
        do_start(8'h5A, 8'h33, 1'b0, 1'b1, 9'h08D, t1);
        ia          = 8'h00;
        ib          = 8'hFF;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_start_ready", 32'(start_ready), 32'd0);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        wait_done(t1, lat);
        chk("latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            ia          = 8'h11;
            ib          = 8'h22;
            start_valid = 1'b1;
            chk("hold_done_valid", 32'(done_valid), 32'd1);
            chk("hold_start_ready", 32'(start_ready), 32'd0);
            chk("hold_result", 32'({ocarry, os}), 32'h08D);
            @(posedge clk);
            #1;
        end
        start_valid = 1'b0;
        done_ready  = 1'b1;
        @(posedge clk);
        #1;
        chk("post_done_valid", 32'(done_valid), 32'd0);
        chk("post_start_ready", 32'(start_ready), 32'd1);
        chk("post_result_held", 32'({ocarry, os}), 32'h08D);

        // Carry-out boundaries
        do_start(8'hFF, 8'h01, 1'b0, 1'b1, 9'h100, t1);
        wait_done(t1, lat);
        do_start(8'hFF, 8'hFF, 1'b1, 1'b1, 9'h1FF, t1);
        wait_done(t1, lat);

        // Reset at RUN bit index 3 discards the operation
        do_start(8'h12, 8'h34, 1'b0, 1'b0, 9'h000, t1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done_valid", 32'(done_valid), 32'd0);
        chk("midrst_result", 32'({ocarry, os}), 32'd0);
        chk("midrst_start_ready", 32'(start_ready), 32'd1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done_valid) seen = 1'b1;
        end
        chk("no_done_after_rst", 32'(seen), 32'd0);

        // Reset wins over a simultaneous start
        rst         = 1'b1;
        start_valid = 1'b1;
        ia          = 8'h77;
        ib          = 8'h01;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        start_valid = 1'b0;
        chk("rst_vs_start_busy", 32'(busy), 32'd0);
        chk("rst_vs_start_ready", 32'(start_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("rst_vs_start_idle", 32'(busy), 32'd0);

        // Back-to-back issue at the minimum interval
        do_start(8'h01, 8'h01, 1'b0, 1'b1, 9'h002, t1);
        do_start(8'h80, 8'h80, 1'b0, 1'b1, 9'h100, t2);
        chk("issue_interval", 32'(t2 - t1), 32'd10);
        wait_done(t2, lat);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
